// File: rtl/wave_pkg.sv
// wave_pkg: register map, CTRL bit positions and FSM encoding shared by
// the wave_meas top level.
package wave_pkg;

    localparam int DATA_W = 32;

    // Register offsets (word index taken from addr[4:2])
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_HIGH    = 3'd1;
    localparam logic [2:0] REG_LOW     = 3'd2;
    localparam logic [2:0] REG_PERIOD  = 3'd3;
    localparam logic [2:0] REG_EDGES   = 3'd4;
    localparam logic [2:0] REG_TMO     = 3'd5;
    localparam logic [2:0] REG_AMP_MIN = 3'd6;
    localparam logic [2:0] REG_AMP_MAX = 3'd7;

    // CTRL write bits
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_HIGH    = 3'd2,
        ST_LOW     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

endpackage

// File: rtl/wave_meas_edge_sync.sv
// edge_sync: two-flop synchronizer for the timed wave bit followed by a
// registered rise/fall pulse detector. A pin change shows up as a
// one-cycle pulse three clocks later.
module edge_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_q;
    logic fall_q;

    // Synchronizer chain plus registered edge pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/wave_meas.sv
// wave_meas: measures one high/low period of wave_in[0] after a start
// command and reports HIGH, LOW, PERIOD and EDGES through a small
// register interface, with optional timeout.
// Define WAVE_MEAS_AMP_EN to also track min/max of the full wave_in word.
module wave_meas
    import wave_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] wave_in,
    output logic        irq
);

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W] ? '1 : s[DATA_W-1:0];
    endfunction

    state_e state_q, state_d;
    logic [DATA_W-1:0] high_q, high_d;
    logic [DATA_W-1:0] low_q, low_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic [DATA_W-1:0] edges_q, edges_d;
    logic [DATA_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0] tmo_lim_q, tmo_lim_d;
    logic [DATA_W-1:0] tmo_next;
    logic [DATA_W-1:0] amp_min;
    logic [DATA_W-1:0] amp_max;

    logic [2:0] reg_sel;
    logic       wr_en;
    logic       ctrl_wr;
    logic       start;
    logic       clear;
    logic       rise;
    logic       fall;
    logic       busy;
    logic       st_done;
    logic       st_timeout;
    logic       tmo_hit;
    logic       bus_unused;

    assign reg_sel    = addr[4:2];
    assign bus_unused = ^{addr[31:5], addr[1:0]};
    assign wr_en      = |wstrb;
    assign ctrl_wr    = wr_en && (reg_sel == REG_CTRL);
    // Clear takes priority: a start bit written together with clear is dropped.
    assign clear      = ctrl_wr && wdata[CTRL_CLEAR_BIT];
    assign start      = ctrl_wr && wdata[CTRL_START_BIT] && !wdata[CTRL_CLEAR_BIT];

    assign busy       = (state_q == ST_ARM) || (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign st_done    = (state_q == ST_DONE);
    assign st_timeout = (state_q == ST_TIMEOUT);
    assign irq        = st_done | st_timeout;

    // Timeout fires on the cycle the elapsed count reaches the limit.
    assign tmo_next   = sat_inc(tmo_cnt_q);
    assign tmo_hit    = busy && (tmo_lim_q != '0) && (tmo_next >= tmo_lim_q);

    edge_sync u_edge_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (wave_in[0]),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Next-state and counter update logic
    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        low_d     = low_q;
        period_d  = period_q;
        edges_d   = edges_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_lim_d = tmo_lim_q;

        if (wr_en && (reg_sel == REG_TMO)) begin
            tmo_lim_d = wdata;
        end

        if (clear) begin
            state_d   = ST_IDLE;
            high_d    = '0;
            low_d     = '0;
            period_d  = '0;
            edges_d   = '0;
            tmo_cnt_d = '0;
        end else if (start) begin
            state_d   = ST_ARM;
            high_d    = '0;
            low_d     = '0;
            period_d  = '0;
            edges_d   = '0;
            tmo_cnt_d = '0;
        end else if (busy) begin
            tmo_cnt_d = tmo_next;
            if (rise || fall) begin
                edges_d = sat_inc(edges_q);
            end
            if (state_q == ST_HIGH) begin
                high_d = sat_inc(high_q);
            end
            if (state_q == ST_LOW) begin
                low_d = sat_inc(low_q);
            end
            if (tmo_hit) begin
                state_d = ST_TIMEOUT;
            end else begin
                case (state_q)
                    ST_ARM:  if (rise) state_d = ST_HIGH;
                    ST_HIGH: if (fall) state_d = ST_LOW;
                    ST_LOW: begin
                        if (rise) begin
                            state_d  = ST_DONE;
                            period_d = sat_add(high_q, sat_inc(low_q));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            edges_q   <= '0;
            tmo_cnt_q <= '0;
            tmo_lim_q <= '0;
        end else begin
            state_q   <= state_d;
            high_q    <= high_d;
            low_q     <= low_d;
            period_q  <= period_d;
            edges_q   <= edges_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_lim_q <= tmo_lim_d;
        end
    end

`ifdef WAVE_MEAS_AMP_EN
    logic [DATA_W-1:0] amp_min_q, amp_min_d;
    logic [DATA_W-1:0] amp_max_q, amp_max_d;

    // Running min/max of the full wave word while a period is being timed
    always_comb begin
        amp_min_d = amp_min_q;
        amp_max_d = amp_max_q;
        if (clear) begin
            amp_min_d = '0;
            amp_max_d = '0;
        end else if (start) begin
            amp_min_d = '1;
            amp_max_d = '0;
        end else if ((state_q == ST_HIGH) || (state_q == ST_LOW)) begin
            if (wave_in < amp_min_q) amp_min_d = wave_in;
            if (wave_in > amp_max_q) amp_max_d = wave_in;
        end
    end

    // Amplitude registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            amp_min_q <= '0;
            amp_max_q <= '0;
        end else begin
            amp_min_q <= amp_min_d;
            amp_max_q <= amp_max_d;
        end
    end

    assign amp_min = amp_min_q;
    assign amp_max = amp_max_q;
`else
    logic wave_unused;
    assign wave_unused = ^wave_in[31:1];
    assign amp_min     = '0;
    assign amp_max     = '0;
`endif

    // Combinational register read mux
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:    rdata = {29'b0, st_timeout, st_done, busy};
            REG_HIGH:    rdata = high_q;
            REG_LOW:     rdata = low_q;
            REG_PERIOD:  rdata = period_q;
            REG_EDGES:   rdata = edges_q;
            REG_TMO:     rdata = tmo_lim_q;
            REG_AMP_MIN: rdata = amp_min;
            REG_AMP_MAX: rdata = amp_max;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_wave_meas.sv
// tb_wave_meas: directed bench for wave_meas with a behavioural reference
// model checked every cycle and literal expectations for key scenarios.
module tb_wave_meas;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] wave_in = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit gen_mode = 1'b0;
    logic [31:0] wave_val = 32'h0;
    int gcnt = 0;
    logic [2:0] sweep = 3'd0;

    always #5 clk = ~clk;

    wave_meas dut (
        .clk     (clk),
        .resetn  (resetn),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .wave_in (wave_in),
        .irq     (irq)
    );

    // Wave source: either a held value or a repeating 3-high/5-low pattern
    always @(negedge clk) begin
        if (!gen_mode) begin
            wave_in <= wave_val;
            gcnt    <= 0;
        end else begin
            wave_in <= (gcnt < 3) ? 32'd1 : 32'd0;
            gcnt    <= (gcnt == 7) ? 0 : gcnt + 1;
        end
    end

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_ARM = 1, P_HIGH = 2, P_LOW = 3, P_DONE = 4, P_TMO = 5;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    int     phase;
    longint m_high, m_low, m_period, m_edges, m_cyc, m_lim, m_amin, m_amax;
    longint new_lim;
    bit [3:0] hist;   // hist[n] = wave bit sampled n+1 clocks ago
    bit mr, mf;

    function automatic longint satp(input longint v);
        return (v > SAT) ? SAT : v;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase = P_IDLE;
            m_high = 0; m_low = 0; m_period = 0; m_edges = 0;
            m_cyc = 0; m_lim = 0; m_amin = 0; m_amax = 0;
            hist = 4'b0;
        end else begin
            // a pin change reaches the measurement logic three clocks later
            mr = hist[2] & ~hist[3];
            mf = ~hist[2] & hist[3];
            new_lim = m_lim;
            if (|wstrb && addr[4:2] == 3'd5) new_lim = longint'(wdata);
            if (|wstrb && addr[4:2] == 3'd0 && wdata[1]) begin
                phase = P_IDLE;
                m_high = 0; m_low = 0; m_period = 0; m_edges = 0; m_cyc = 0;
                m_amin = 0; m_amax = 0;
            end else if (|wstrb && addr[4:2] == 3'd0 && wdata[0]) begin
                phase = P_ARM;
                m_high = 0; m_low = 0; m_period = 0; m_edges = 0; m_cyc = 0;
                m_amin = SAT; m_amax = 0;
            end else if (phase == P_ARM || phase == P_HIGH || phase == P_LOW) begin
                m_cyc = satp(m_cyc + 1);
                if (mr || mf) m_edges = satp(m_edges + 1);
                if (phase == P_HIGH) m_high = satp(m_high + 1);
                if (phase == P_LOW)  m_low  = satp(m_low + 1);
                if (phase == P_HIGH || phase == P_LOW) begin
                    if (longint'(wave_in) < m_amin) m_amin = longint'(wave_in);
                    if (longint'(wave_in) > m_amax) m_amax = longint'(wave_in);
                end
                if (m_lim != 0 && m_cyc >= m_lim) phase = P_TMO;
                else if (phase == P_ARM && mr) phase = P_HIGH;
                else if (phase == P_HIGH && mf) phase = P_LOW;
                else if (phase == P_LOW && mr) begin
                    phase = P_DONE;
                    m_period = satp(m_high + m_low);
                end
            end
            m_lim = new_lim;
            hist = {hist[2:0], wave_in[0]};
        end
    end

    function automatic logic [31:0] m_reg(input logic [2:0] s);
        logic [31:0] r;
        r = '0;
        case (s)
            3'd0: r = {29'b0, phase == P_TMO, phase == P_DONE,
                       (phase == P_ARM || phase == P_HIGH || phase == P_LOW)};
            3'd1: r = m_high[31:0];
            3'd2: r = m_low[31:0];
            3'd3: r = m_period[31:0];
            3'd4: r = m_edges[31:0];
            3'd5: r = m_lim[31:0];
`ifdef WAVE_MEAS_AMP_EN
            3'd6: r = m_amin[31:0];
            3'd7: r = m_amax[31:0];
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic m_irq();
        return (phase == P_DONE) || (phase == P_TMO);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, got, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk($sformatf("model_rdata_reg%0d", addr[4:2]), rdata, m_reg(addr[4:2]));
            chk("model_irq", {31'b0, irq}, {31'b0, m_irq()});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            sweep++;
            addr = {27'b0, sweep, 2'b00};
        end
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] d, input logic [3:0] strb = 4'hF);
        @(negedge clk);
        addr  = {27'b0, sel, 2'b00};
        wdata = d;
        wstrb = strb;
        @(negedge clk);
        wstrb = 4'h0;
        wdata = 32'h0;
    endtask

    task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string name);
        @(negedge clk);
        addr = {27'b0, sel, 2'b00};
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic wait_irq(input int maxc, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            sweep++;
            addr = {27'b0, sweep, 2'b00};
            #1;
            if (irq) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: irq actual=0 required=1 within %0d cycles", name, maxc);
        end
    endtask

    task automatic wait_high(input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            addr = 32'h4;
            #1;
            if (rdata != 32'h0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_high: HIGH actual=0 required=nonzero within %0d cycles", maxc);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rd(3'd0, 32'd0, "reset_status");
        chk("reset_irq", {31'b0, irq}, 32'd0);
        rd(3'd5, 32'd0, "reset_tmo");
        @(negedge clk);
        resetn = 1'b1;
        rd(3'd1, 32'd0, "post_reset_high");

        // 3 high / 5 low measurement, no timeout
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd1);
        gen_mode = 1'b1;
        wait_irq(60, "done_irq");
        rd(3'd0, 32'd2, "done_status");
        rd(3'd1, 32'd3, "high");
        rd(3'd2, 32'd5, "low");
        rd(3'd3, 32'd8, "period");
        rd(3'd4, 32'd3, "edges");
        chk("done_irq_level", {31'b0, irq}, 32'd1);
        tick(10);
        rd(3'd1, 32'd3, "high_held");
        wr(3'd3, 32'hDEAD_BEEF);
        rd(3'd3, 32'd8, "period_readonly");
        wr(3'd5, 32'd77, 4'h0);
        rd(3'd5, 32'd0, "tmo_strb0_ignored");

        // timeout with wave held low
        gen_mode = 1'b0;
        wave_val = 32'd0;
        tick(8);
        wr(3'd5, 32'd10);
        rd(3'd5, 32'd10, "tmo_rw");
        wr(3'd0, 32'd1);
        tick(8);
        rd(3'd0, 32'd1, "tmo_busy_cycle9");
        rd(3'd0, 32'd4, "tmo_status");
        chk("tmo_irq", {31'b0, irq}, 32'd1);
        rd(3'd1, 32'd0, "tmo_high");

        // clear+start together while busy
        wr(3'd5, 32'd1000);
        wr(3'd0, 32'd1);
        gen_mode = 1'b1;
        tick(6);
        rd(3'd0, 32'd1, "busy_before_clear");
        wr(3'd0, 32'd3);
        rd(3'd0, 32'd0, "clear_status");
        chk("clear_irq", {31'b0, irq}, 32'd0);
        rd(3'd1, 32'd0, "clear_high");
        rd(3'd5, 32'd1000, "clear_tmo_kept");

        // amplitude words 7, 2, 9 during measurement
        gen_mode = 1'b0;
        wave_val = 32'd0;
        tick(8);
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd1);
        tick(3);
        wave_val = 32'd7;
        tick(4);
        wave_val = 32'd2;
        tick(4);
        wave_val = 32'd9;
        wait_irq(40, "amp_irq");
`ifdef WAVE_MEAS_AMP_EN
        rd(3'd6, 32'd2, "amp_min");
        rd(3'd7, 32'd9, "amp_max");
`else
        rd(3'd6, 32'd0, "amp_min_disabled");
        rd(3'd7, 32'd0, "amp_max_disabled");
`endif

        // reset pulse while in HIGH
        wave_val = 32'd0;
        tick(8);
        wr(3'd5, 32'd500);
        wr(3'd0, 32'd1);
        gen_mode = 1'b1;
        wait_high(40);
        @(negedge clk);
        resetn = 1'b0;
        rd(3'd0, 32'd0, "abort_status");
        rd(3'd1, 32'd0, "abort_high");
        rd(3'd4, 32'd0, "abort_edges");
        rd(3'd5, 32'd0, "abort_tmo");
        chk("abort_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rd(3'd0, 32'd0, "post_abort_status");
        rd(3'd2, 32'd0, "post_abort_low");
        gen_mode = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
